// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the five-stage MIPS core.
// Decodes the D-stage instruction once, carries the resulting control bundle
// through E/M/W stage registers, and computes the D-stage stall from
// Tuse/Tnew register-dependency timing plus a multiply/divide busy counter.
module ctrl_pipe #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic [2:0]  d_pc_sel,
  output logic [1:0]  d_ext_sel,
  output logic [2:0]  d_branch_sel,
  output logic [3:0]  e_alu_sel,
  output logic        e_alu_a_shamt,
  output logic        e_alu_b_imm,
  output logic [2:0]  e_mdu_sel,
  output logic        e_mdu_start,
  output logic        e_mdu_rd_hi,
  output logic        e_mdu_to_result,
  output logic        m_dm_we,
  output logic [1:0]  m_store_type,
  output logic [2:0]  m_load_type,
  output logic        w_grf_we,
  output logic [1:0]  w_grf_wd_sel,
  output logic [4:0]  w_grf_a3,
  output logic        mdu_busy
);

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI = 6'h08,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e,
                         OP_LUI     = 6'h0f, OP_LB     = 6'h20, OP_LH   = 6'h21,
                         OP_LW      = 6'h23, OP_LBU    = 6'h24, OP_LHU  = 6'h25,
                         OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW   = 6'h2b;

  // SPECIAL function codes
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV  = 6'h07,
                         F_JR   = 6'h08, F_JALR = 6'h09, F_MFHI  = 6'h10,
                         F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1a,
                         F_DIVU = 6'h1b, F_ADD  = 6'h20, F_ADDU  = 6'h21,
                         F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND   = 6'h24,
                         F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27,
                         F_SLT  = 6'h2a, F_SLTU = 6'h2b;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                         ALU_SRA = 4'd8, ALU_SLT = 4'd9, ALU_SLTU = 4'd10;

  localparam logic [2:0] MDU_MULT = 3'd1, MDU_MULTU = 3'd2, MDU_DIV = 3'd3,
                         MDU_DIVU = 3'd4, MDU_MTHI  = 3'd5, MDU_MTLO = 3'd6;

  localparam logic [1:0] WD_ALU = 2'd0, WD_DM = 2'd1, WD_EXT = 2'd2, WD_PC8 = 2'd3;

  // Tuse value meaning "register not read"; larger than any Tnew so it never stalls.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Control carried into E; tnew is the cycles until the result exists.
  typedef struct packed {
    logic [3:0] alu_sel;
    logic       alu_a_shamt;
    logic       alu_b_imm;
    logic [2:0] mdu_sel;
    logic       mdu_start;
    logic       mdu_rd_hi;
    logic       mdu_to_result;
    logic       dm_we;
    logic [1:0] store_type;
    logic [2:0] load_type;
    logic       grf_we;
    logic [1:0] wd_sel;
    logic [4:0] a3;
    logic [1:0] tnew;
  } e_ctrl_t;

  typedef struct packed {
    logic       dm_we;
    logic [1:0] store_type;
    logic [2:0] load_type;
    logic       grf_we;
    logic [1:0] wd_sel;
    logic [4:0] a3;
    logic [1:0] tnew;
  } m_ctrl_t;

  typedef struct packed {
    logic       grf_we;
    logic [1:0] wd_sel;
    logic [4:0] a3;
  } w_ctrl_t;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op    = instr_d[31:26];
  assign rs    = instr_d[25:21];
  assign rt    = instr_d[20:16];
  assign rd    = instr_d[15:11];
  assign funct = instr_d[5:0];

  e_ctrl_t          dec;
  logic [2:0]       pc_sel, branch_sel;
  logic [1:0]       ext_sel;
  logic [1:0]       tuse_rs, tuse_rt;
  logic             is_md, r_alu, i_alu;

  e_ctrl_t          e_d, e_q;
  m_ctrl_t          m_d, m_q;
  w_ctrl_t          w_d, w_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stall_e, stall_m, stall_md;

  // Instruction decode: D-side selects, E bundle, and per-source Tuse.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec        = '0;
    pc_sel     = 3'd0;
    ext_sel    = 2'd0;
    branch_sel = 3'd0;
    tuse_rs    = TUSE_NONE;
    tuse_rt    = TUSE_NONE;
    is_md      = 1'b0;
    r_alu      = 1'b0;
    i_alu      = 1'b0;
    case (op)
      OP_SPECIAL: begin
        // The all-zero word is the canonical nop; any other funct-0 word is a real sll.
        if (instr_d != 32'h0) begin
          case (funct)
            F_ADD, F_ADDU: begin r_alu = 1'b1; dec.alu_sel = ALU_ADD; end
            F_SUB, F_SUBU: begin r_alu = 1'b1; dec.alu_sel = ALU_SUB; end
            F_AND:  begin r_alu = 1'b1; dec.alu_sel = ALU_AND; end
            F_OR:   begin r_alu = 1'b1; dec.alu_sel = ALU_OR;  end
            F_XOR:  begin r_alu = 1'b1; dec.alu_sel = ALU_XOR; end
            F_NOR:  begin r_alu = 1'b1; dec.alu_sel = ALU_NOR; end
            F_SLT:  begin r_alu = 1'b1; dec.alu_sel = ALU_SLT; end
            F_SLTU: begin r_alu = 1'b1; dec.alu_sel = ALU_SLTU; end
            F_SLL:  begin r_alu = 1'b1; dec.alu_sel = ALU_SLL; dec.alu_a_shamt = 1'b1; end
            F_SRL:  begin r_alu = 1'b1; dec.alu_sel = ALU_SRL; dec.alu_a_shamt = 1'b1; end
            F_SRA:  begin r_alu = 1'b1; dec.alu_sel = ALU_SRA; dec.alu_a_shamt = 1'b1; end
            F_SLLV: begin r_alu = 1'b1; dec.alu_sel = ALU_SLL; end
            F_SRLV: begin r_alu = 1'b1; dec.alu_sel = ALU_SRL; end
            F_SRAV: begin r_alu = 1'b1; dec.alu_sel = ALU_SRA; end
            F_JR: begin
              pc_sel  = 3'd3;
              tuse_rs = 2'd0;
            end
            F_JALR: begin
              pc_sel     = 3'd3;
              tuse_rs    = 2'd0;
              dec.grf_we = 1'b1;
              dec.a3     = rd;
              dec.wd_sel = WD_PC8;
            end
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              dec.mdu_sel   = (funct == F_MULT)  ? MDU_MULT  :
                              (funct == F_MULTU) ? MDU_MULTU :
                              (funct == F_DIV)   ? MDU_DIV   : MDU_DIVU;
              dec.mdu_start = 1'b1;
              tuse_rs       = 2'd1;
              tuse_rt       = 2'd1;
              is_md         = 1'b1;
            end
            F_MTHI, F_MTLO: begin
              dec.mdu_sel   = (funct == F_MTHI) ? MDU_MTHI : MDU_MTLO;
              dec.mdu_start = 1'b1;
              tuse_rs       = 2'd1;
              is_md         = 1'b1;
            end
            F_MFHI, F_MFLO: begin
              dec.mdu_rd_hi     = (funct == F_MFHI);
              dec.mdu_to_result = 1'b1;
              dec.grf_we        = 1'b1;
              dec.a3            = rd;
              dec.tnew          = 2'd1;
              is_md             = 1'b1;
            end
            default: ;
          endcase
        end
      end
      OP_ADDI, OP_ADDIU: begin i_alu = 1'b1; dec.alu_sel = ALU_ADD; end
      OP_SLTI:  begin i_alu = 1'b1; dec.alu_sel = ALU_SLT; end
      OP_SLTIU: begin i_alu = 1'b1; dec.alu_sel = ALU_SLTU; end
      OP_ANDI:  begin i_alu = 1'b1; dec.alu_sel = ALU_AND; ext_sel = 2'd1; end
      OP_ORI:   begin i_alu = 1'b1; dec.alu_sel = ALU_OR;  ext_sel = 2'd1; end
      OP_XORI:  begin i_alu = 1'b1; dec.alu_sel = ALU_XOR; ext_sel = 2'd1; end
      OP_LUI: begin
        ext_sel    = 2'd2;
        dec.grf_we = 1'b1;
        dec.a3     = rt;
        dec.wd_sel = WD_EXT;
      end
      OP_BEQ, OP_BNE: begin
        pc_sel     = 3'd1;
        branch_sel = (op == OP_BEQ) ? 3'd0 : 3'd1;
        tuse_rs    = 2'd0;
        tuse_rt    = 2'd0;
      end
      OP_BLEZ, OP_BGTZ: begin
        pc_sel     = 3'd1;
        branch_sel = (op == OP_BLEZ) ? 3'd2 : 3'd3;
        tuse_rs    = 2'd0;
      end
      OP_REGIMM: begin
        if (rt == 5'd0 || rt == 5'd1) begin
          pc_sel     = 3'd1;
          branch_sel = (rt == 5'd0) ? 3'd4 : 3'd5;
          tuse_rs    = 2'd0;
        end
      end
      OP_J: pc_sel = 3'd2;
      OP_JAL: begin
        pc_sel     = 3'd2;
        dec.grf_we = 1'b1;
        dec.a3     = 5'd31;
        dec.wd_sel = WD_PC8;
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        dec.alu_b_imm = 1'b1;
        dec.grf_we    = 1'b1;
        dec.a3        = rt;
        dec.wd_sel    = WD_DM;
        dec.tnew      = 2'd2;
        dec.load_type = (op == OP_LW)  ? 3'd0 :
                        (op == OP_LH)  ? 3'd1 :
                        (op == OP_LHU) ? 3'd2 :
                        (op == OP_LB)  ? 3'd3 : 3'd4;
        tuse_rs       = 2'd1;
      end
      OP_SW, OP_SH, OP_SB: begin
        dec.alu_b_imm  = 1'b1;
        dec.dm_we      = 1'b1;
        dec.store_type = (op == OP_SW) ? 2'd0 : (op == OP_SH) ? 2'd1 : 2'd2;
        tuse_rs        = 2'd1;
        tuse_rt        = 2'd2;
      end
      default: ;
    endcase

    // Common fields of the register-register and register-immediate ALU groups.
    if (r_alu) begin
      dec.grf_we = 1'b1;
      dec.a3     = rd;
      dec.tnew   = 2'd1;
      tuse_rt    = 2'd1;
      if (!dec.alu_a_shamt) tuse_rs = 2'd1;
    end
    if (i_alu) begin
      dec.grf_we    = 1'b1;
      dec.a3        = rt;
      dec.tnew      = 2'd1;
      dec.alu_b_imm = 1'b1;
      tuse_rs       = 2'd1;
    end
  end

  // Hazard detection: operand needed before the producer in E or M can supply it.
  always_comb begin
    stall_e  = e_q.grf_we && (e_q.a3 != 5'd0) &&
               (((e_q.a3 == rs) && (tuse_rs < e_q.tnew)) ||
                ((e_q.a3 == rt) && (tuse_rt < e_q.tnew)));
    stall_m  = m_q.grf_we && (m_q.a3 != 5'd0) &&
               (((m_q.a3 == rs) && (tuse_rs < m_q.tnew)) ||
                ((m_q.a3 == rt) && (tuse_rt < m_q.tnew)));
    stall_md = is_md && ((cnt_q != '0) || e_q.mdu_start);
    stall    = stall_e || stall_m || stall_md;
  end

  // Next-stage bundles: a stall turns E into a bubble, M and W always advance.
  always_comb begin
    e_d            = stall ? '0 : dec;
    m_d.dm_we      = e_q.dm_we;
    m_d.store_type = e_q.store_type;
    m_d.load_type  = e_q.load_type;
    m_d.grf_we     = e_q.grf_we;
    m_d.wd_sel     = e_q.wd_sel;
    m_d.a3         = e_q.a3;
    m_d.tnew       = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
    w_d.grf_we     = m_q.grf_we;
    w_d.wd_sel     = m_q.wd_sel;
    w_d.a3         = m_q.a3;
  end

  // Busy counter: reload when mult/div leaves E, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (e_q.mdu_sel == MDU_MULT || e_q.mdu_sel == MDU_MULTU)
      cnt_d = CNT_W'(MULT_CYCLES);
    else if (e_q.mdu_sel == MDU_DIV || e_q.mdu_sel == MDU_DIVU)
      cnt_d = CNT_W'(DIV_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Stage registers and busy counter, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign d_pc_sel        = pc_sel;
  assign d_ext_sel       = ext_sel;
  assign d_branch_sel    = branch_sel;
  assign e_alu_sel       = e_q.alu_sel;
  assign e_alu_a_shamt   = e_q.alu_a_shamt;
  assign e_alu_b_imm     = e_q.alu_b_imm;
  assign e_mdu_sel       = e_q.mdu_sel;
  assign e_mdu_start     = e_q.mdu_start;
  assign e_mdu_rd_hi     = e_q.mdu_rd_hi;
  assign e_mdu_to_result = e_q.mdu_to_result;
  assign m_dm_we         = m_q.dm_we;
  assign m_store_type    = m_q.store_type;
  assign m_load_type     = m_q.load_type;
  assign w_grf_we        = w_q.grf_we;
  assign w_grf_wd_sel    = w_q.wd_sel;
  assign w_grf_a3        = w_q.a3;
  assign mdu_busy        = (cnt_q != '0);

endmodule
